// File: rtl/rom_stream_reader_32.sv
// rom_stream_reader_32
//   Reads a run of consecutive 32-bit words from a ROM that has one cycle of
//   read latency, and presents them as a valid/ready stream. A 2-entry buffer
//   covers the read latency. The stream runs at one word per clock with no
//   gaps, and no word is dropped or repeated when the consumer stalls.
//
// Ports
//   i_clk       clock, rising edge
//   i_nrst      asynchronous active-low reset
//   i_start     start request, sampled only in IDLE
//   i_base      first word address, captured with i_start
//   i_count     number of words (0 is legal), captured with i_start
//   i_abort     cancels a transfer in RUN (highest priority)
//   o_busy      high while in RUN
//   o_done      one-cycle pulse on normal completion
//   o_rom_addr  ROM address, driven from the read pointer
//   i_rom_data  ROM data, valid the cycle after the address was sampled
//   o_data      head of the buffer
//   o_valid     buffer not empty
//   i_ready     consumer accepts o_data when o_valid && i_ready
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_start
// RUN   | issuing reads and draining the buffer
// DONE  | one-cycle completion pulse, then back to IDLE

module rom_stream_reader_32 #(
  parameter int abits = 12
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_start,
  input  logic [abits-1:0] i_base,
  input  logic [abits:0]   i_count,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic [abits-1:0] o_rom_addr,
  input  logic [31:0]      i_rom_data,
  output logic [31:0]      o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [abits-1:0] ADDR_ONE = 1;
  localparam logic [abits:0]   CNT_ONE  = 1;

  state_t         state;
  logic [abits:0] issue_cnt;
  logic [abits:0] out_cnt;
  logic           pending;
  logic [31:0]    buf_q [2];
  logic           rd_idx;
  logic           wr_idx;
  logic [1:0]     occ;

  logic           pop;
  logic           push;
  logic           issue;
  logic [2:0]     load;

  assign o_valid = (occ != 2'd0);
  assign o_data  = buf_q[rd_idx];

  assign pop  = o_valid & i_ready;
  assign push = pending;

  // Words that will occupy the buffer once the in-flight read lands, after
  // this cycle's pop. A new read is only issued if it will have a slot.
  // pop implies occ >= 1, so the subtraction cannot underflow.
  assign load = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};

  assign issue = (state == ST_RUN) && !i_abort &&
                 (issue_cnt != '0) && (load < 3'd2);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state      <= ST_IDLE;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_rom_addr <= '0;
      issue_cnt  <= '0;
      out_cnt    <= '0;
      pending    <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      rd_idx     <= 1'b0;
      wr_idx     <= 1'b0;
      occ        <= 2'd0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            o_rom_addr <= i_base;
            issue_cnt  <= i_count;
            out_cnt    <= i_count;
            if (i_count == '0) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              state  <= ST_RUN;
              o_busy <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (i_abort) begin
            // Drop everything; the pointer is reloaded by the next start.
            state     <= ST_IDLE;
            o_busy    <= 1'b0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            pending   <= 1'b0;
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
            rd_idx    <= 1'b0;
            wr_idx    <= 1'b0;
            occ       <= 2'd0;
          end else begin
            if (issue) begin
              o_rom_addr <= o_rom_addr + ADDR_ONE;
              issue_cnt  <= issue_cnt - CNT_ONE;
            end
            pending <= issue;

            if (push) begin
              buf_q[wr_idx] <= i_rom_data;
              wr_idx        <= ~wr_idx;
            end

            if (pop) begin
              rd_idx  <= ~rd_idx;
              out_cnt <= out_cnt - CNT_ONE;
            end

            occ <= occ + {1'b0, push} - {1'b0, pop};

            if (pop && (out_cnt == CNT_ONE)) begin
              state  <= ST_DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_reader_32.sv
module tb_rom_stream_reader_32;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [11:0] base;
  logic [12:0] count;
  logic        abort;
  logic        busy;
  logic        done;
  logic [11:0] rom_addr;
  logic [31:0] rom_q;
  logic [31:0] data;
  logic        valid;
  logic        ready;

  int total = 0;
  int bad   = 0;

  rom_stream_reader_32 #(.abits(12)) dut (
    .i_clk      (clk),
    .i_nrst     (nrst),
    .i_start    (start),
    .i_base     (base),
    .i_count    (count),
    .i_abort    (abort),
    .o_busy     (busy),
    .o_done     (done),
    .o_rom_addr (rom_addr),
    .i_rom_data (rom_q),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [11:0] a);
    return {4'hD, a, ~a, 4'h5};
  endfunction

  // One-cycle-latency ROM.
  always @(posedge clk) rom_q <= rom_fn(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts a transfer (caller is at a negedge), then drains it using the
  // ready pattern rpat (bit k = ready in cycle k after start, 1 beyond 31).
  // If poke is set, a conflicting i_start is held during the first cycles.
  task automatic stream(input string tag, input logic [11:0] b, input logic [12:0] cnt,
                        input logic [31:0] rpat, input bit poke,
                        output int first_cyc, output int last_cyc);
    int          got;
    int          cyc;
    logic [11:0] issued;
    logic [11:0] exp_a;
    base  = b;
    count = cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_addr0"}, 32'(rom_addr), 32'(b));
    got       = 0;
    cyc       = 0;
    first_cyc = -1;
    last_cyc  = -1;
    while (got < int'(cnt) && cyc < 60) begin
      ready = (cyc < 32) ? rpat[cyc] : 1'b1;
      if (poke && cyc < 3) begin
        start = 1'b1;
        base  = 12'h200;
        count = 13'd7;
      end else begin
        start = 1'b0;
      end
      issued = rom_addr - b;
      check({tag, "_lead"}, 32'((int'(issued) - got) <= 2), 32'd1);
      if (valid && ready) begin
        exp_a = b + got[11:0];
        check({tag, "_data"}, data, rom_fn(exp_a));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_count"}, 32'(got), 32'(cnt));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_valid_end"}, 32'(valid), 32'd0);
    exp_a = b + cnt[11:0];
    check({tag, "_addr_end"}, 32'(rom_addr), 32'(exp_a));
    @(negedge clk);
    check({tag, "_done_off"}, 32'(done), 32'd0);
    check({tag, "_valid_off"}, 32'(valid), 32'd0);
  endtask

  int fc;
  int lc;

  initial begin
    nrst  = 1'b0;
    start = 1'b0;
    base  = '0;
    count = '0;
    abort = 1'b0;
    ready = 1'b0;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_valid", 32'(valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);

    // Streaming, 4 words, ready held high
    stream("strm", 12'h010, 13'd4, 32'hFFFF_FFFF, 1'b0, fc, lc);
    check("strm_first", 32'(fc), 32'd2);
    check("strm_last", 32'(lc), 32'd5);

    // Backpressure: 4 ready, 5 stalled, then toggling
    stream("bp", 12'h123, 13'd8, 32'hAAAA_AA0F, 1'b0, fc, lc);

    // Address wrap
    stream("wrap", 12'hFFE, 13'd4, 32'hFFFF_FFFF, 1'b0, fc, lc);
    check("wrap_last", 32'(lc), 32'd5);

    // Zero-length transfer
    ready = 1'b1;
    base  = 12'h300;
    count = 13'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_valid", 32'(valid), 32'd0);
    @(negedge clk);
    check("zero_done_off", 32'(done), 32'd0);
    check("zero_valid2", 32'(valid), 32'd0);

    // Start while busy is ignored; length stays 3
    stream("sbusy", 12'h100, 13'd3, 32'hFFFF_FFFF, 1'b1, fc, lc);

    // Abort after 2 of 6 words
    ready = 1'b1;
    base  = 12'h040;
    count = 13'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ab_w0", data, rom_fn(12'h040));
    @(negedge clk);
    check("ab_w1", data, rom_fn(12'h041));
    @(negedge clk);
    ready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_valid", 32'(valid), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    @(negedge clk);
    check("ab_done2", 32'(done), 32'd0);
    check("ab_valid2", 32'(valid), 32'd0);
    stream("ab_new", 12'h050, 13'd3, 32'hFFFF_FFFF, 1'b0, fc, lc);

    // Reset pulse after 2 of 6 words
    ready = 1'b1;
    base  = 12'h060;
    count = 13'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rs_w0", data, rom_fn(12'h060));
    @(negedge clk);
    check("rs_w1", data, rom_fn(12'h061));
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_valid", 32'(valid), 32'd0);
    check("rs_done", 32'(done), 32'd0);
    check("rs_data", data, 32'd0);
    check("rs_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("rs_done2", 32'(done), 32'd0);
    check("rs_valid2", 32'(valid), 32'd0);
    stream("rs_new", 12'h070, 13'd5, 32'hFFFF_FFFF, 1'b0, fc, lc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
